// File: rtl/bus_responder.sv
// Bus responder: demuxes a phased CPU bus onto a 64-byte RAM.
// Option: BUS_RESP_ERRCNT_EN adds a saturating unmapped-access counter.
module bus_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phase,
  input  logic [7:0]  ab_mux,
  input  logic [7:0]  db_in,
  input  logic        cpu_oe,
  output logic [7:0]  db_out,
  output logic        db_oe,
  output logic [15:0] addr_out,
  output logic        wr_stb,
  output logic        rd_stb,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    S_SYNC,
    S_HI,
    S_LO
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ph_q;
  logic [7:0]  r_hi_q;
  logic [7:0]  r_lo_q;
  logic [7:0]  r_wd_q;
  logic        r_wr_q;
  logic        r_last_rd;
  logic [15:0] r_addr;
  logic [7:0]  r_db_out;
  logic        r_wr_stb;
  logic        r_rd_stb;
  logic [7:0]  r_ram [64];

  logic        w_commit;
  logic        w_map;
  logic        w_smp_hi;
  logic        w_smp_lo;
  logic [5:0]  w_idx;

  // Phase history; resets high so a release mid-high waits for a real rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph_q <= 1'b1;
    end else begin
      r_ph_q <= phase;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and commit decision, advanced only by phase level/edges.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    unique case (r_state)
      S_SYNC: begin
        if (phase && !r_ph_q) begin
          w_state_nxt = S_HI;
        end
      end
      S_HI: begin
        if (!phase) begin
          w_state_nxt = S_LO;
        end
      end
      S_LO: begin
        if (phase) begin
          w_state_nxt = S_HI;
          w_commit    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_SYNC;
      end
    endcase
  end

  assign w_smp_hi = (w_state_nxt == S_HI);
  assign w_smp_lo = (w_state_nxt == S_LO);
  assign w_map    = (r_hi_q == 8'h00) && (r_lo_q[7:6] == 2'b00);
  assign w_idx    = r_lo_q[5:0];

  // Per-phase capture of address halves, write data and direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_q <= 8'h00;
      r_lo_q <= 8'h00;
      r_wd_q <= 8'h00;
      r_wr_q <= 1'b0;
    end else begin
      if (w_smp_hi) begin
        r_hi_q <= ab_mux;
        r_wd_q <= db_in;
        r_wr_q <= cpu_oe;
      end
      if (w_smp_lo) begin
        r_lo_q <= ab_mux;
      end
    end
  end

  // Commit: latch address, pulse a strobe, register read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= 16'h0000;
      r_db_out  <= 8'h00;
      r_wr_stb  <= 1'b0;
      r_rd_stb  <= 1'b0;
      r_last_rd <= 1'b0;
    end else begin
      r_wr_stb <= w_commit && r_wr_q;
      r_rd_stb <= w_commit && !r_wr_q;
      if (w_commit) begin
        r_addr    <= {r_hi_q, r_lo_q};
        r_last_rd <= !r_wr_q;
        if (!r_wr_q) begin
          r_db_out <= w_map ? r_ram[w_idx] : 8'hFF;
        end
      end
    end
  end

  // RAM store; unmapped writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        r_ram[i] <= 8'h00;
      end
    end else if (w_commit && r_wr_q && w_map) begin
      r_ram[w_idx] <= r_wd_q;
    end
  end

`ifdef BUS_RESP_ERRCNT_EN
  logic [7:0] r_err;

  // Saturating count of commits that missed the RAM window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 8'h00;
    end else if (w_commit && !w_map && (r_err != 8'hFF)) begin
      r_err <= r_err + 8'd1;
    end
  end

  assign err_count = r_err;
`else
  assign err_count = 8'h00;
`endif

  assign db_oe    = (r_state == S_HI) && r_last_rd && !cpu_oe;
  assign db_out   = r_db_out;
  assign addr_out = r_addr;
  assign wr_stb   = r_wr_stb;
  assign rd_stb   = r_rd_stb;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder.
// Expected err_count follows BUS_RESP_ERRCNT_EN.
module tb_bus_responder;

  logic        clk;
  logic        rst_n;
  logic        phase;
  logic [7:0]  ab_mux;
  logic [7:0]  db_in;
  logic        cpu_oe;
  logic [7:0]  db_out;
  logic        db_oe;
  logic [15:0] addr_out;
  logic        wr_stb;
  logic        rd_stb;
  logic [7:0]  err_count;

  int n_tests;
  int n_fail;
  int n_wr;
  int n_rd;
  int b_wr;
  int b_rd;

`ifdef BUS_RESP_ERRCNT_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif

  bus_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase     (phase),
    .ab_mux    (ab_mux),
    .db_in     (db_in),
    .cpu_oe    (cpu_oe),
    .db_out    (db_out),
    .db_oe     (db_oe),
    .addr_out  (addr_out),
    .wr_stb    (wr_stb),
    .rd_stb    (rd_stb),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_stb === 1'b1) n_wr <= n_wr + 1;
    if (rd_stb === 1'b1) n_rd <= n_rd + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_err(input int n);
    if (!EC) return 8'h00;
    if (n > 255) return 8'hFF;
    return n[7:0];
  endfunction

  task automatic hi_ph(input logic [7:0] a,
                       input logic [7:0] d,
                       input logic oe);
    @(negedge clk);
    phase  = 1'b1;
    ab_mux = a;
    db_in  = d;
    cpu_oe = oe;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic lo_ph(input logic [7:0] a);
    @(negedge clk);
    phase  = 1'b0;
    ab_mux = a;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [7:0] h,
                     input logic [7:0] l,
                     input logic [7:0] d,
                     input logic oe);
    hi_ph(h, d, oe);
    lo_ph(l);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    phase = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic snap();
    @(negedge clk);
    #1;
    b_wr = n_wr;
    b_rd = n_rd;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    phase  = 1'b0;
    ab_mux = 8'h00;
    db_in  = 8'h00;
    cpu_oe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (addr_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_addr: got %h want 0000", addr_out);
    end
    n_tests++;
    if (db_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_dbout: got %h want 00", db_out);
    end
    n_tests++;
    if ({db_oe, wr_stb, rd_stb} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_ctl: got %b want 000",
               {db_oe, wr_stb, rd_stb});
    end
    n_tests++;
    if (err_count !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_err: got %h want 00", err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    snap();
    cyc(8'h00, 8'h12, 8'h5A, 1'b1);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (n_wr - b_wr !== 1 || n_rd - b_rd !== 0) begin
      n_fail++;
      $display("FAIL wr_stb: got wr=%0d rd=%0d want 1 0",
               n_wr - b_wr, n_rd - b_rd);
    end
    n_tests++;
    if (addr_out !== 16'h0012) begin
      n_fail++;
      $display("FAIL wr_addr: got %h want 0012", addr_out);
    end
    n_tests++;
    if (db_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_dboe: got %b want 0", db_oe);
    end
    lo_ph(8'h12);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (n_wr - b_wr !== 1 || n_rd - b_rd !== 1) begin
      n_fail++;
      $display("FAIL rd_stb: got wr=%0d rd=%0d want 1 1",
               n_wr - b_wr, n_rd - b_rd);
    end
    n_tests++;
    if (db_out !== 8'h5A) begin
      n_fail++;
      $display("FAIL rd_data: got %h want 5a", db_out);
    end
    n_tests++;
    if (db_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_dboe: got %b want 1", db_oe);
    end
    lo_ph(8'h00);
    n_tests++;
    if (db_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL lo_dboe: got %b want 0", db_oe);
    end
    hi_ph(8'h00, 8'h00, 1'b1);
    n_tests++;
    if (db_out !== 8'h00 || db_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL rd0_cont: got %h/%b want 00/0",
               db_out, db_oe);
    end
    do_reset();
  endtask

  task automatic test_unmapped();
    snap();
    cyc(8'h12, 8'h34, 8'h00, 1'b0);
    hi_ph(8'h80, 8'h77, 1'b1);
    n_tests++;
    if (db_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL unm_rd: got %h want ff", db_out);
    end
    n_tests++;
    if (err_count !== exp_err(1)) begin
      n_fail++;
      $display("FAIL unm_err1: got %h want %h",
               err_count, exp_err(1));
    end
    lo_ph(8'h00);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (addr_out !== 16'h8000 || n_wr - b_wr !== 1) begin
      n_fail++;
      $display("FAIL unm_wr: got %h/%0d want 8000/1",
               addr_out, n_wr - b_wr);
    end
    lo_ph(8'h00);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (db_out !== 8'h00) begin
      n_fail++;
      $display("FAIL unm_drop: got %h want 00", db_out);
    end
    n_tests++;
    if (err_count !== exp_err(2)) begin
      n_fail++;
      $display("FAIL unm_err2: got %h want %h",
               err_count, exp_err(2));
    end
    do_reset();
    #1;
    n_tests++;
    if (err_count !== 8'h00) begin
      n_fail++;
      $display("FAIL err_rst: got %h want 00", err_count);
    end
  endtask

  task automatic test_glitch();
    snap();
    @(negedge clk);
    phase  = 1'b1;
    ab_mux = 8'hFF;
    db_in  = 8'h11;
    cpu_oe = 1'b1;
    @(negedge clk);
    ab_mux = 8'h00;
    db_in  = 8'h22;
    @(negedge clk);
    db_in  = 8'h3C;
    @(negedge clk);
    phase  = 1'b0;
    ab_mux = 8'h40;
    @(negedge clk);
    ab_mux = 8'h05;
    @(posedge clk);
    #1;
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (n_wr - b_wr !== 1 || addr_out !== 16'h0005) begin
      n_fail++;
      $display("FAIL glitch_wr: got %0d/%h want 1/0005",
               n_wr - b_wr, addr_out);
    end
    lo_ph(8'h05);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (db_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL glitch_rd: got %h want 3c", db_out);
    end
    do_reset();
  endtask

  task automatic test_midcycle_reset();
    snap();
    hi_ph(8'h00, 8'h99, 1'b1);
    @(negedge clk);
    phase  = 1'b0;
    ab_mux = 8'h07;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    phase  = 1'b1;
    ab_mux = 8'h00;
    cpu_oe = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lo_ph(8'h07);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (n_wr - b_wr !== 0 || n_rd - b_rd !== 0) begin
      n_fail++;
      $display("FAIL sync_nostb: got wr=%0d rd=%0d want 0 0",
               n_wr - b_wr, n_rd - b_rd);
    end
    lo_ph(8'h07);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (n_rd - b_rd !== 1 || n_wr - b_wr !== 0) begin
      n_fail++;
      $display("FAIL sync_first: got wr=%0d rd=%0d want 0 1",
               n_wr - b_wr, n_rd - b_rd);
    end
    n_tests++;
    if (db_out !== 8'h00 || addr_out !== 16'h0007) begin
      n_fail++;
      $display("FAIL abandon: got %h/%h want 00/0007",
               db_out, addr_out);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    snap();
    cyc(8'h00, 8'h3F, 8'hA1, 1'b1);
    cyc(8'h00, 8'h40, 8'hB2, 1'b1);
    cyc(8'h00, 8'h3F, 8'h00, 1'b0);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (db_out !== 8'hA1) begin
      n_fail++;
      $display("FAIL b2b_3f: got %h want a1", db_out);
    end
    n_tests++;
    if (n_wr - b_wr !== 2 || n_rd - b_rd !== 1) begin
      n_fail++;
      $display("FAIL b2b_cnt: got wr=%0d rd=%0d want 2 1",
               n_wr - b_wr, n_rd - b_rd);
    end
    lo_ph(8'h40);
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (db_out !== 8'hFF || addr_out !== 16'h0040) begin
      n_fail++;
      $display("FAIL b2b_40: got %h/%h want ff/0040",
               db_out, addr_out);
    end
    n_tests++;
    if (err_count !== exp_err(2)) begin
      n_fail++;
      $display("FAIL b2b_err: got %h want %h",
               err_count, exp_err(2));
    end
    do_reset();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 200; i++) begin
      cyc(8'h12, 8'h34, 8'h00, 1'b0);
    end
    n_tests++;
    if (err_count !== exp_err(199)) begin
      n_fail++;
      $display("FAIL sat_mid: got %h want %h",
               err_count, exp_err(199));
    end
    for (int i = 0; i < 100; i++) begin
      cyc(8'h12, 8'h34, 8'h00, 1'b0);
    end
    hi_ph(8'h00, 8'h00, 1'b0);
    n_tests++;
    if (err_count !== exp_err(300)) begin
      n_fail++;
      $display("FAIL sat_end: got %h want %h",
               err_count, exp_err(300));
    end
    do_reset();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_wr    = 0;
    n_rd    = 0;
    b_wr    = 0;
    b_rd    = 0;
    test_reset();
    test_write_read();
    test_unmapped();
    test_glitch();
    test_midcycle_reset();
    test_back_to_back();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
